pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC width in bits.
REQ-002 SHALL have parameter INST_BYTES, default 4, meaning sequential increment; power of two.
REQ-003 SHALL have parameter RESET_VEC, default 32'h0, meaning PC value loaded at reset.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries; used only with PC_RAS_EN.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-008 SHALL have port stall, input, 1, hold PC and instruction_en.
REQ-009 SHALL have port halt, input, 1, enter HALTED.
REQ-010 SHALL have port exc_req, input, 1, exception redirect.
REQ-011 SHALL have port exc_vec, input, ADDR_W, exception target.
REQ-012 SHALL have port branch_taken, input, 1, branch redirect.
REQ-013 SHALL have port branch_target, input, ADDR_W, branch target.
REQ-014 SHALL have port jump, input, 1, jump redirect.
REQ-015 SHALL have port jump_target, input, ADDR_W, jump target.
REQ-016 SHALL have port call, input, 1, jump is a call; qualifies jump.
REQ-017 SHALL have port ret, input, 1, return redirect.
REQ-018 SHALL have port pc, output, ADDR_W, current instruction address (registered).
REQ-019 SHALL have port pc_next_seq, output, ADDR_W, pc+INST_BYTES (combinational).
REQ-020 SHALL have port instruction_en, output, 1, pc is a valid fetch address (registered).
REQ-021 SHALL have port misalign, output, 1, one-cycle pulse for a misaligned redirect target (registered).
REQ-022 SHALL have port ras_empty, output, 1, return stack empty.

Function
REQ-023 SHALL implement FSM states RESET, RUN, HALTED.
- RESET->RUN on the first edge with rst=1; pc holds RESET_VEC; instruction_en<=1.
REQ-024 In RUN, SHALL select the next pc by strict priority:
- exc_req -> exc_vec
- stall -> hold pc and instruction_en
- halt -> HALTED, pc held, instruction_en<=0
- branch_taken -> branch_target
- ret -> return target
- jump -> jump_target
- else -> pc+INST_BYTES
REQ-025 exc_req SHALL override stall and halt; redirects arriving during stall are dropped, and upstream holds them until stall=0.
REQ-026 In HALTED, SHALL hold pc with instruction_en=0; exc_req -> RUN, pc<=exc_vec, instruction_en<=1; all other inputs ignored.
REQ-027 Redirect targets SHALL have their low log2(INST_BYTES) bits forced to 0; misalign<=1 for one cycle if any forced bit was 1.
REQ-028 Sequential increment SHALL wrap modulo 2^ADDR_W; all-ones-aligned +INST_BYTES -> 0, with no flag.
REQ-029 Redirect latency SHALL be one cycle: input sampled at edge N, new pc visible after edge N.

Reset
REQ-030 With rst=0 at a clock edge, SHALL set pc<=RESET_VEC, instruction_en<=0, misalign<=0, state<=RESET, and clear the RAS (ras_empty=1), regardless of the other inputs or the current state.
REQ-031 Reset mid-stall or mid-HALTED SHALL behave identically to reset from RUN.

Configuration
REQ-032 Macro PC_RAS_EN SHALL control the return-address stack.
- Defined: an accepted jump&&call pushes pc+INST_BYTES, and an accepted ret pops with return target = top.
- Defined, ret while empty: target=jump_target.
- Defined, push when full: overwrites the oldest entry (circular).
- Defined, simultaneous call and ret: ret wins; no push.
REQ-033 Without PC_RAS_EN, ret SHALL redirect to jump_target, call SHALL be ignored, ras_empty SHALL be tied 1, and no RAS storage SHALL exist.

Structure
REQ-034 Shared package pc_pkg SHALL hold the FSM state enum and the redirect-source enum (EXC, BRANCH, RET, JUMP, SEQ).
REQ-035 RAS SHALL be a sub-module pc_ras (push, pop, top, empty, full, depth parameter), instantiated only under PC_RAS_EN.

Verification
REQ-036 Bench SHALL cover:
- Reset: rst=0 for 2 cycles, then 1 -> pc=0 with instruction_en=0, then pc=0 with instruction_en=1, then 4, 8.
- Priority: at pc=0x10, assert branch_taken (target 0x40) and jump (target 0x80) together -> pc=0x40; with stall=1 and exc_req (vec 0x100) -> pc=0x100.
- Halt: halt at pc=0x20 -> instruction_en=0, pc=0x20 held 5 cycles; exc_req (vec 0x200) -> pc=0x200, instruction_en=1.
- Alignment/wrap: jump_target=0x43 -> pc=0x40, misalign pulse; pc=0xFFFFFFFC seq -> 0x0, no misalign.
- RAS (PC_RAS_EN, depth 4): 5 calls from 0x0,0x100,0x200,0x300,0x400 then 5 rets -> 0x404,0x304,0x204,0x104, then jump_target; ras_empty=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: FSM states and redirect sources.
package pc_pkg;

    typedef enum logic [1:0] {
        RESET,
        RUN,
        HALTED
    } pc_state_t;

    typedef enum logic [2:0] {
        EXC,
        BRANCH,
        RET,
        JUMP,
        SEQ
    } redir_src_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push into a full stack overwrites the oldest entry.
module pc_ras #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
    endfunction

    assign top   = mem[ptr_dec(wr_ptr)];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Saturating count lets the write pointer lap the oldest entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (pop && !empty) begin
            wr_ptr <= ptr_dec(wr_ptr);
            count  <= count - 1'b1;
        end else if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
            if (!full) begin
                count <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push && !pop) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit with prioritised redirects, halt and stall handling.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC  = 32'h0,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_vec,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next_seq,
    output logic              instruction_en,
    output logic              misalign,
    output logic              ras_empty
);

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(INST_BYTES - 1);

    pc_state_t         state, state_next;
    redir_src_t        src;
    logic              advance;
    logic [ADDR_W-1:0] raw_target, ret_target, pc_next;
    logic              en_next, misalign_next;

`ifdef PC_RAS_EN
    logic              ras_push, ras_pop, unused_ras_full;
    logic [ADDR_W-1:0] ras_top;

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_next_seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (unused_ras_full)
    );

    assign ret_target = ras_empty ? jump_target : ras_top;
`else
    logic unused_cfg;

    assign unused_cfg = call | (RAS_DEPTH == 0);
    assign ras_empty  = 1'b1;
    assign ret_target = jump_target;
`endif

    assign pc_next_seq = pc + ADDR_W'(INST_BYTES);

    always_comb begin
        state_next    = state;
        src           = SEQ;
        advance       = 1'b0;
        en_next       = instruction_en;
        raw_target    = pc_next_seq;
        pc_next       = pc;
        misalign_next = 1'b0;
`ifdef PC_RAS_EN
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
`endif
        case (state)
            RESET: begin
                state_next = RUN;
                en_next    = 1'b1;
            end
            RUN: begin
                advance = 1'b1;
                if (exc_req) begin
                    src = EXC;
                end else if (stall) begin
                    advance = 1'b0;
                end else if (halt) begin
                    advance    = 1'b0;
                    state_next = HALTED;
                    en_next    = 1'b0;
                end else if (branch_taken) begin
                    src = BRANCH;
                end else if (ret) begin
                    src = RET;
`ifdef PC_RAS_EN
                    ras_pop = !ras_empty;
`endif
                end else if (jump) begin
                    src = JUMP;
`ifdef PC_RAS_EN
                    ras_push = call;
`endif
                end
            end
            HALTED: begin
                if (exc_req) begin
                    src        = EXC;
                    advance    = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RESET;
        endcase

        case (src)
            EXC:     raw_target = exc_vec;
            BRANCH:  raw_target = branch_target;
            RET:     raw_target = ret_target;
            JUMP:    raw_target = jump_target;
            default: raw_target = pc_next_seq;
        endcase

        // Redirect targets are forced onto an instruction boundary; flag any dropped bits.
        if (advance) begin
            pc_next       = raw_target & ~OFF_MASK;
            en_next       = 1'b1;
            misalign_next = (src != SEQ) && |(raw_target & OFF_MASK);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= RESET;
            pc             <= RESET_VEC;
            instruction_en <= 1'b0;
            misalign       <= 1'b0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            instruction_en <= en_next;
            misalign       <= misalign_next;
        end
    end

endmodule
